// File: rtl/note_seq_regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : piano_pkg                                                  |
// | Brief   : Shared types for the note sequencer register file.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package piano_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RECORD = 2'b01,
        PLAY   = 2'b10
    } seq_state_t;

endpackage : piano_pkg
`default_nettype wire

// File: rtl/note_seq_regfile_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : note_regfile                                               |
// | Brief   : DEPTH x DATA_W async-reset storage, 1 write, 2 comb reads. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module note_regfile #(
    parameter  int DATA_W = 4,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_a = r_mem[raddr_a];
    assign rdata_b = r_mem[raddr_b];

endmodule : note_regfile
`default_nettype wire

// File: rtl/note_seq_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : note_seq_regfile                                           |
// | Brief   : Note register file with record / tempo-driven playback.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module note_seq_regfile
    import piano_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rw,
    input  logic [ADDR_W-1:0] adress,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic              loop,
    input  logic              note_valid,
    input  logic [DATA_W-1:0] note_in,
    input  logic              tick,
    output logic              play_valid,
    output logic [DATA_W-1:0] play_note,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic [1:0]        state
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_ONE   = (ADDR_W+1)'(1);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_play_valid;
    logic [DATA_W-1:0] r_play_note;

    logic              w_we;
    logic              w_rec_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rd_direct;
    logic [DATA_W-1:0] w_rd_play;
    logic              w_last;

    // Single write port: direct writes only in IDLE, recorded notes only in RECORD.
    always_comb begin
        w_rec_we = 1'b0;
        w_we     = 1'b0;
        w_waddr  = adress;
        w_wdata  = datain;
        case (r_state)
            IDLE: begin
                w_we = rw;
            end
            RECORD: begin
                w_rec_we = note_valid && (r_count < c_DEPTH);
                w_we     = w_rec_we;
                w_waddr  = r_wr_ptr;
                w_wdata  = note_in;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    assign w_last = ({1'b0, r_rd_ptr} == (r_count - c_ONE));

    note_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (w_we),
        .waddr   (w_waddr),
        .wdata   (w_wdata),
        .raddr_a (adress),
        .rdata_a (w_rd_direct),
        .raddr_b (r_rd_ptr),
        .rdata_b (w_rd_play)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_play_valid <= 1'b0;
            r_play_note  <= '0;
        end else begin
            r_play_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rec_start) begin
                        r_state  <= RECORD;
                        r_wr_ptr <= '0;
                        r_count  <= '0;
                    end else if (play_start && (r_count != '0)) begin
                        r_state  <= PLAY;
                        r_rd_ptr <= '0;
                    end
                end
                RECORD: begin
                    if (w_rec_we) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_count  <= r_count + c_ONE;
                        if ((r_count + c_ONE) == c_DEPTH) begin
                            r_state <= IDLE;
                        end
                    end
                    if (stop) begin
                        r_state <= IDLE;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        r_state <= IDLE;
                    end else if (tick) begin
                        r_play_note  <= w_rd_play;
                        r_play_valid <= 1'b1;
                        if (w_last) begin
                            r_rd_ptr <= '0;
                            if (!loop) begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dataout    = rw ? '0 : w_rd_direct;
    assign play_valid = r_play_valid;
    assign play_note  = r_play_note;
    assign count      = r_count;
    assign full       = (r_count == c_DEPTH);
    assign state      = r_state;

endmodule : note_seq_regfile
`default_nettype wire
